product_accumulate_scale: RTL and testbench

- Stage directly downstream of the shift-add multiplier.
- Accepts signed 16-bit products one per handshake and sums a fixed number of terms (dot-product style) in a wide accumulator.
- After the last term, rounds the sum, rescales it back to operand fixed-point format and saturates it to the operand width.
- Presents the result on a valid/ready output port.

---
 rtl/product_accumulate_scale.sv | 116 +++++++++++
 tb/tb_product_accumulate_scale.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/product_accumulate_scale.sv
// product_accumulate_scale: sums a fixed number of signed products, then
// rounds, rescales and saturates the sum onto a valid/ready output port.
module product_accumulate_scale #(
    parameter int Product_Width = 16,
    parameter int Acc_Width     = 24,
    parameter int Out_Width     = 8,
    parameter int Frac_Bits     = 4,
    parameter int Term_Count    = 4,
    parameter int Count_Width   = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic signed [Product_Width-1:0] product,
    input  logic                            prod_valid,
    output logic                            prod_ready,
    output logic        [Out_Width-1:0]     out_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic                            sat,
    output logic        [Count_Width-1:0]   term_cnt
);

    typedef enum logic [1:0] {
        ACCUM,
        ROUND,
        HOLD
    } state_t;

    // Rounding and clipping are evaluated one bit wider than the accumulator
    // so that adding the half-LSB constant can never wrap.
    localparam logic signed [Acc_Width:0] L_HALF =
        (Acc_Width+1)'(1) <<< (Frac_Bits - 1);
    localparam logic signed [Acc_Width:0] L_MAX =
        (Acc_Width+1)'((2 ** (Out_Width - 1)) - 1);
    localparam logic signed [Acc_Width:0] L_MIN = ~L_MAX;
    localparam logic [Count_Width-1:0] L_LAST = Count_Width'(Term_Count - 1);
    localparam logic [Out_Width-1:0] L_OUT_MAX = {1'b0, {(Out_Width-1){1'b1}}};
    localparam logic [Out_Width-1:0] L_OUT_MIN = {1'b1, {(Out_Width-1){1'b0}}};

    state_t                          r_state;
    logic signed [Acc_Width-1:0]     r_acc;
    logic        [Count_Width-1:0]   r_term_cnt;
    logic        [Out_Width-1:0]     r_out_data;
    logic                            r_out_valid;
    logic                            r_sat;

    logic signed [Acc_Width-1:0]     w_prod_ext;
    logic signed [Acc_Width:0]       w_acc_ext;
    logic signed [Acc_Width:0]       w_sum;
    logic signed [Acc_Width:0]       w_r;
    logic                            w_accept;

    assign w_prod_ext = Acc_Width'(product);
    assign w_acc_ext  = {r_acc[Acc_Width-1], r_acc};
    assign w_sum      = w_acc_ext + L_HALF;
    assign w_r        = w_sum >>> Frac_Bits;

    assign prod_ready = (r_state == ACCUM);
    assign w_accept   = prod_valid && prod_ready;

    assign out_data   = r_out_data;
    assign out_valid  = r_out_valid;
    assign sat        = r_sat;
    assign term_cnt   = r_term_cnt;

    // Group sequencer: accumulate terms, round once, hold until consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ACCUM;
            r_acc       <= '0;
            r_term_cnt  <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_sat       <= 1'b0;
        end else begin
            unique case (r_state)
                ACCUM: begin
                    if (w_accept) begin
                        r_acc <= r_acc + w_prod_ext;
                        if (r_term_cnt == L_LAST) begin
                            r_term_cnt <= '0;
                            r_state    <= ROUND;
                        end else begin
                            r_term_cnt <= r_term_cnt + 1'b1;
                        end
                    end
                end
                ROUND: begin
                    if (w_r > L_MAX) begin
                        r_out_data <= L_OUT_MAX;
                        r_sat      <= 1'b1;
                    end else if (w_r < L_MIN) begin
                        r_out_data <= L_OUT_MIN;
                        r_sat      <= 1'b1;
                    end else begin
                        r_out_data <= w_r[Out_Width-1:0];
                        r_sat      <= 1'b0;
                    end
                    r_out_valid <= 1'b1;
                    r_state     <= HOLD;
                end
                HOLD: begin
                    if (r_out_valid && out_ready) begin
                        r_out_valid <= 1'b0;
                        r_acc       <= '0;
                        r_state     <= ACCUM;
                    end
                end
                default: begin
                    r_state <= ACCUM;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_product_accumulate_scale.sv
// Scoreboard bench for product_accumulate_scale: directed groups from the
// test plan followed by randomized products, gaps and backpressure.
module tb_product_accumulate_scale;

    localparam int PW = 16;
    localparam int AW = 24;
    localparam int OW = 8;
    localparam int FB = 4;
    localparam int TC = 4;
    localparam int CW = 8;

    typedef struct {
        logic [OW-1:0] d;
        bit            s;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic signed [PW-1:0] product = '0;
    logic                 prod_valid = 1'b0;
    logic                 prod_ready;
    logic        [OW-1:0] out_data;
    logic                 out_valid;
    logic                 out_ready = 1'b1;
    logic                 sat;
    logic        [CW-1:0] term_cnt;

    int checks = 0;
    int errors = 0;
    int rdy_mode = 0;

    exp_t q[$];
    int   m_cnt = 0;
    int   m_sum = 0;
    bit   m_busy = 0;
    bit   m_round = 0;
    bit   m_hold = 0;

    product_accumulate_scale #(
        .Product_Width(PW),
        .Acc_Width(AW),
        .Out_Width(OW),
        .Frac_Bits(FB),
        .Term_Count(TC),
        .Count_Width(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .product(product),
        .prod_valid(prod_valid),
        .prod_ready(prod_ready),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sat(sat),
        .term_cnt(term_cnt)
    );

    always #5 clk = ~clk;

    // Reference: round half toward +inf by floor division, then clip.
    function automatic exp_t model(input int s);
        exp_t e;
        int   x;
        int   r;
        int   dv;
        dv = 1 << FB;
        x  = s + (1 << (FB - 1));
        if (x >= 0) r = x / dv;
        else        r = -((-x + dv - 1) / dv);
        if (r > (1 << (OW - 1)) - 1) begin
            r   = (1 << (OW - 1)) - 1;
            e.s = 1'b1;
        end else if (r < -(1 << (OW - 1))) begin
            r   = -(1 << (OW - 1));
            e.s = 1'b1;
        end else begin
            e.s = 1'b0;
        end
        e.d = r[OW-1:0];
        return e;
    endfunction

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
        end
    endtask

    // out_ready owner: 0 = high, 1 = low, 2 = random
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'b0;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor: compare handshake/output behaviour against the model.
    always @(negedge clk) begin
        bit exp_ready;
        if (rst) begin
            q.delete();
            m_cnt   = 0;
            m_sum   = 0;
            m_busy  = 0;
            m_round = 0;
            m_hold  = 0;
        end else begin
            exp_ready = !m_busy;
            chk("prod_ready", int'(prod_ready), int'(exp_ready));
            chk("term_cnt", int'(term_cnt), m_cnt);
            chk("out_valid", int'(out_valid), int'(m_hold));
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_output", 1, 0);
                end else begin
                    chk("out_data", int'(out_data), int'(q[0].d));
                    chk("sat", int'(sat), int'(q[0].s));
                    if (out_ready) begin
                        void'(q.pop_front());
                        m_hold = 0;
                        m_busy = 0;
                    end
                end
            end
            if (m_round) begin
                m_round = 0;
                m_hold  = 1;
            end else if (prod_valid && exp_ready) begin
                m_sum += int'(product);
                m_cnt++;
                if (m_cnt == TC) begin
                    q.push_back(model(m_sum));
                    m_sum   = 0;
                    m_cnt   = 0;
                    m_busy  = 1;
                    m_round = 1;
                end
            end
        end
    end

    // Present a product and keep it until the DUT takes it.
    task automatic put(input logic signed [PW-1:0] v);
        int n;
        prod_valid = 1'b1;
        product    = v;
        n = 0;
        @(negedge clk);
        while (!prod_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("put_timeout", 1, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        prod_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int n;
        prod_valid = 1'b0;
        n = 0;
        while ((q.size() != 0 || m_busy) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 200) chk("drain_timeout", 1, 0);
    endtask

    task automatic do_reset();
        prod_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int n;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_sat", int'(sat), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_term_cnt", int'(term_cnt), 0);
        chk("rst_prod_ready", int'(prod_ready), 1);
        @(posedge clk);
        #1;

        put(16); put(32); put(48); put(64);
        drain();
        for (int i = 0; i < 4; i++) put(-24);
        drain();
        put(8); put(0); put(0); put(0);
        drain();
        put(-8); put(0); put(0); put(0);
        drain();
        for (int i = 0; i < 4; i++) put(16'sh4000);
        drain();
        for (int i = 0; i < 4; i++) put(16'sh8000);
        drain();

        // backpressure with products pressing on a busy block
        rdy_mode = 1;
        put(100); put(-3); put(77); put(5);
        prod_valid = 1'b1;
        product = 16'sh0010;
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        prod_valid = 1'b0;
        rdy_mode = 0;
        drain();
        for (int i = 0; i < 4; i++) put(16);
        drain();

        // gapped input
        put(16); idle(2); put(32); put(48); idle(1); put(64);
        drain();

        // reset mid-group
        put(16); put(16);
        do_reset();
        for (int i = 0; i < 4; i++) put(16);
        drain();

        // randomized groups
        rdy_mode = 2;
        for (int g = 0; g < 40; g++) begin
            for (int t = 0; t < TC; t++) begin
                if ($urandom_range(0, 9) < 3) idle($urandom_range(1, 2));
                if (g < 10) put(PW'($urandom_range(0, 1) ? 16'sh7fff : 16'sh8000));
                else        put(PW'($urandom()));
            end
        end
        drain();
        rdy_mode = 0;
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
